// File: rtl/simd_act_pkg.sv
// Shared types and constants for the SIMD activation pipeline.
package simd_act_pkg;

    typedef enum logic [1:0] {
        ACT_BYPASS = 2'd0,
        ACT_RELU   = 2'd1,
        ACT_LEAKY  = 2'd2,
        ACT_CLIP   = 2'd3
    } act_mode_e;

    localparam int unsigned DEF_DATA_W      = 16;
    localparam int unsigned DEF_LANES       = 4;
    localparam int unsigned DEF_LEAKY_SHIFT = 3;

    // Bits needed to hold a count of 0..n zeroed lanes.
    function automatic int unsigned popcnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/simd_activation_pipe_if.sv
// Valid/ready input and output streams of the SIMD activation pipeline.
interface simd_activation_pipe_if
    import simd_act_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned LANES  = DEF_LANES
);
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*DATA_W-1:0]   in_data;
    logic [1:0]                in_mode;
    logic [DATA_W-1:0]         in_clip_max;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*DATA_W-1:0]   out_data;

    modport master (
        output in_valid, in_data, in_mode, in_clip_max, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_mode, in_clip_max, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/simd_activation_pipe_act_lane.sv
// Combinational single-lane activation: bypass, ReLU, leaky ReLU, clipped ReLU.
module act_lane
    import simd_act_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned LEAKY_SHIFT = DEF_LEAKY_SHIFT
) (
    input  logic [DATA_W-1:0] x,
    input  act_mode_e         mode,
    input  logic [DATA_W-1:0] clip_max,
    output logic [DATA_W-1:0] y,
    output logic              zeroed
);
    logic neg;

    assign neg = x[DATA_W-1];

    always_comb begin
        y = x;
        unique case (mode)
            ACT_BYPASS: y = x;
            ACT_RELU:   y = neg ? '0 : x;
            ACT_LEAKY:  y = neg ? DATA_W'($signed(x) >>> LEAKY_SHIFT) : x;
            ACT_CLIP:   y = neg ? '0 : ((x > clip_max) ? clip_max : x);
            default:    y = x;
        endcase
    end

    // Only lanes that were nonzero and became zero count as zeroed.
    assign zeroed = (y == '0) && (x != '0);

endmodule

// File: rtl/simd_activation_pipe.sv
// Two-stage valid/ready multi-lane activation unit.
// Optional zeroed-lane statistics counter enabled by defining ACT_STATS_EN.
module simd_activation_pipe
    import simd_act_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned LANES       = DEF_LANES,
    parameter int unsigned LEAKY_SHIFT = DEF_LEAKY_SHIFT
) (
    input  logic                  clk,
    input  logic                  rst,
    simd_activation_pipe_if.slave bus,
    input  logic                  stat_clr,
    output logic [31:0]           stat_zero_cnt
);
    localparam int unsigned W = LANES * DATA_W;

    logic              s1_valid;
    logic [W-1:0]      s1_data;
    act_mode_e         s1_mode;
    logic [DATA_W-1:0] s1_clip;
    logic              s2_valid;
    logic [W-1:0]      s2_data;
    logic              s1_load;
    logic              s2_load;
    logic [W-1:0]      act_data;
    logic [LANES-1:0]  lane_zeroed;

    assign s2_load      = !s2_valid || bus.out_ready;
    assign s1_load      = !s1_valid || s2_load;
    assign bus.in_ready = s1_load;
    assign bus.out_valid = s2_valid;
    assign bus.out_data  = s2_data;

    // Stage 1: capture the beat together with its mode and clamp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= ACT_BYPASS;
            s1_clip  <= '0;
        end else if (s1_load) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_data <= bus.in_data;
                s1_mode <= act_mode_e'(bus.in_mode);
                s1_clip <= bus.in_clip_max;
            end
        end
    end

    for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
        act_lane #(
            .DATA_W      (DATA_W),
            .LEAKY_SHIFT (LEAKY_SHIFT)
        ) u_lane (
            .x        (s1_data[g*DATA_W +: DATA_W]),
            .mode     (s1_mode),
            .clip_max (s1_clip),
            .y        (act_data[g*DATA_W +: DATA_W]),
            .zeroed   (lane_zeroed[g])
        );
    end

    // Stage 2: hold the activated beat until downstream accepts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= act_data;
            end
        end
    end

`ifdef ACT_STATS_EN
    localparam int unsigned ZW = popcnt_w(LANES);

    logic [ZW-1:0] lane_zcnt;
    logic [ZW-1:0] s2_zcnt;
    logic [31:0]   zero_cnt;
    logic [32:0]   cnt_sum;

    always_comb begin
        lane_zcnt = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_zcnt = lane_zcnt + ZW'(lane_zeroed[i]);
        end
    end

    // Zeroed-lane count rides along with the beat in stage 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_zcnt <= '0;
        end else if (s2_load && s1_valid) begin
            s2_zcnt <= lane_zcnt;
        end
    end

    assign cnt_sum = {1'b0, zero_cnt} + 33'(s2_zcnt);

    // Saturating counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_cnt <= '0;
        end else if (stat_clr) begin
            zero_cnt <= '0;
        end else if (s2_valid && bus.out_ready) begin
            zero_cnt <= cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
        end
    end

    assign stat_zero_cnt = zero_cnt;
`else
    logic unused_stats;

    assign unused_stats  = ^{stat_clr, lane_zeroed};
    assign stat_zero_cnt = '0;
`endif

endmodule

// File: tb/tb_simd_activation_pipe.sv
// Directed and backpressure checks for simd_activation_pipe.
module tb_simd_activation_pipe;
    localparam int unsigned DW = 16;
    localparam int unsigned LN = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        stat_clr;
    logic [31:0] stat_zero_cnt;
    int          total = 0;
    int          bad   = 0;
    longint      exp_stat = 0;

    simd_activation_pipe_if #(.DATA_W(DW), .LANES(LN)) bus ();

    simd_activation_pipe #(
        .DATA_W      (DW),
        .LANES       (LN),
        .LEAKY_SHIFT (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus.slave),
        .stat_clr      (stat_clr),
        .stat_zero_cnt (stat_zero_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] clip;
        logic [63:0] din;
        logic [63:0] dout;
        int          zc;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] m, input logic [15:0] c, input logic [63:0] d);
        bus.in_valid    = 1'b1;
        bus.in_mode     = m;
        bus.in_clip_max = c;
        bus.in_data     = d;
    endtask

    function automatic logic [63:0] exp_cnt();
`ifdef ACT_STATS_EN
        return 64'(exp_stat);
`else
        return 64'd0;
`endif
    endfunction

    // Reference activation in integer arithmetic; floor division for the leaky slope.
    function automatic logic [63:0] ref_beat(input logic [1:0] m, input logic [15:0] c,
                                             input logic [63:0] d, output int zc);
        int x, y;
        logic [63:0] r;
        logic [15:0] lane;
        zc = 0;
        r  = '0;
        for (int i = 0; i < 4; i++) begin
            lane = d[i*16 +: 16];
            x = int'($signed(lane));
            y = x;
            case (m)
                2'd1: if (x < 0) y = 0;
                2'd2: if (x < 0) y = (x - 7) / 8;
                2'd3: if (x < 0) y = 0; else if (x > int'(c)) y = int'(c);
                default: y = x;
            endcase
            r[i*16 +: 16] = 16'(y);
            if (y == 0 && x != 0) zc++;
        end
        return r;
    endfunction

    logic [1:0]  bp_mode[20];
    logic [15:0] bp_clip[20];
    logic [63:0] bp_data[20];
    logic [63:0] sb[$];
    int          zq[$];

    initial begin
        int sent, rcv, occ, zc;
        logic prev_stall, in_hs, out_hs;
        logic [63:0] prev_data, e;

        vecs[0] = '{2'd0, 16'h0000, 64'h7FFF_0001_FFFF_8000, 64'h7FFF_0001_FFFF_8000, 0};
        vecs[1] = '{2'd1, 16'h0000, 64'h8000_1234_0000_FFF0, 64'h0000_1234_0000_0000, 2};
        vecs[2] = '{2'd2, 16'h0000, 64'h0040_8000_FFFF_FFF8, 64'h0040_F000_FFFF_FFFF, 0};
        vecs[3] = '{2'd3, 16'h0600, 64'hFF00_05FF_0600_0700, 64'h0000_05FF_0600_0600, 1};
        vecs[4] = '{2'd3, 16'h7FFF, 64'h0000_0001_8000_7FFF, 64'h0000_0001_0000_7FFF, 1};
        vecs[5] = '{2'd3, 16'h0000, 64'h0001_FFFF_7FFF_1234, 64'h0000_0000_0000_0000, 4};
        vecs[6] = '{2'd2, 16'h0000, 64'h0000_FFF0_7FFF_FFF9, 64'h0000_FFFE_7FFF_FFFF, 0};

        rst = 1'b1;
        stat_clr = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_mode = 2'd0;
        bus.in_clip_max = '0;
        bus.in_data = '0;
        bus.out_ready = 1'b1;

        // Reset state held over several cycles, even with in_valid asserted.
        for (int i = 0; i < 3; i++) begin
            step();
            bus.in_valid = (i == 1);
            #1;
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_out_data", bus.out_data, 0);
            chk("rst_in_ready", bus.in_ready, 1);
            chk("rst_stat", stat_zero_cnt, 0);
        end
        bus.in_valid = 1'b0;
        rst = 1'b0;
        step();

        // Directed vectors: fixed two-cycle latency with out_ready high.
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].mode, vecs[i].clip, vecs[i].din);
            #1;
            chk("vec_in_ready", bus.in_ready, 1);
            step();
            bus.in_valid = 1'b0;
            chk("vec_lat1_valid", bus.out_valid, 0);
            step();
            chk("vec_lat2_valid", bus.out_valid, 1);
            chk($sformatf("vec%0d_data", i), bus.out_data, vecs[i].dout);
            exp_stat += vecs[i].zc;
        end
        step();
        chk("vec_stat", stat_zero_cnt, exp_cnt());
        chk("vec_drained", bus.out_valid, 0);

        // Backpressure: mixed modes, random out_ready, in-order scoreboard.
        for (int i = 0; i < 20; i++) begin
            bp_mode[i] = 2'(i % 4);
            bp_clip[i] = 16'($urandom_range(0, 16'h7FFF));
            bp_data[i] = {$urandom, $urandom};
        end
        sent = 0;
        rcv = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        for (int cyc = 0; cyc < 400 && rcv < 20; cyc++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            if (sent < 20) drive(bp_mode[sent], bp_clip[sent], bp_data[sent]);
            else bus.in_valid = 1'b0;
            #1;
            occ = sent - rcv;
            chk("bp_in_ready", bus.in_ready, !(occ == 2 && !bus.out_ready));
            if (prev_stall) begin
                chk("bp_stall_valid", bus.out_valid, 1);
                chk("bp_stall_data", bus.out_data, prev_data);
            end
            in_hs  = bus.in_valid && bus.in_ready;
            out_hs = bus.out_valid && bus.out_ready;
            if (out_hs) begin
                if (sb.size() == 0) begin
                    chk("bp_spurious_beat", 1, 0);
                end else begin
                    chk("bp_data", bus.out_data, sb.pop_front());
                    exp_stat += zq.pop_front();
                end
                rcv++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            if (in_hs) begin
                e = ref_beat(bp_mode[sent], bp_clip[sent], bp_data[sent], zc);
                sb.push_back(e);
                zq.push_back(zc);
                sent++;
            end
            step();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        chk("bp_all_received", 64'(rcv), 64'd20);
        chk("bp_stat", stat_zero_cnt, exp_cnt());

        // Reset with two beats in flight.
        bus.out_ready = 1'b0;
        drive(vecs[2].mode, vecs[2].clip, vecs[2].din);
        step();
        drive(vecs[6].mode, vecs[6].clip, vecs[6].din);
        step();
        bus.in_valid = 1'b0;
        chk("mr_full_valid", bus.out_valid, 1);
        chk("mr_full_in_ready", bus.in_ready, 0);
        rst = 1'b1;
        #1;
        chk("mr_async_valid", bus.out_valid, 0);
        chk("mr_async_data", bus.out_data, 0);
        chk("mr_async_in_ready", bus.in_ready, 1);
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        exp_stat = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mr_no_stale", bus.out_valid, 0);
        end

        // First beat after reset; clear coincides with its output handshake.
        drive(vecs[1].mode, vecs[1].clip, vecs[1].din);
        step();
        bus.in_valid = 1'b0;
        chk("mr_lat1_valid", bus.out_valid, 0);
        step();
        chk("mr_lat2_valid", bus.out_valid, 1);
        chk("mr_data", bus.out_data, vecs[1].dout);
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        chk("clr_with_hs", stat_zero_cnt, 0);

        drive(vecs[1].mode, vecs[1].clip, vecs[1].din);
        step();
        bus.in_valid = 1'b0;
        step();
        chk("post_clr_data", bus.out_data, vecs[1].dout);
        exp_stat = 2;
        step();
        chk("post_clr_stat", stat_zero_cnt, exp_cnt());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
